// File: rtl/viterbi_pkg.sv
// Shared constants, types and trellis helpers for the K=3, (7,5) Viterbi decoder.
package viterbi_pkg;

    localparam int unsigned K          = 3;
    localparam int unsigned NUM_STATES = 1 << (K - 1);
    localparam int unsigned PM_W       = 5;

    typedef logic [1:0]      state_t;
    typedef logic [PM_W-1:0] pm_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    // Expected encoder output {c0, c1} when input u is shifted in from state s.
    function automatic logic [1:0] exp_sym(input state_t s, input logic u);
        return {u ^ s[1] ^ s[0], u ^ s[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs_node.sv
// One add-compare-select butterfly half: picks the cheaper of two predecessors, saturating.
module viterbi_acs_node #(
    parameter int unsigned PM_W = 5
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W-1:0] pm_new,
    output logic            decision
);

    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    always_comb begin
        sum0  = {1'b0, pm0} + (PM_W+1)'(bm0);
        sum1  = {1'b0, pm1} + (PM_W+1)'(bm1);
        cand0 = sum0[PM_W] ? '1 : sum0[PM_W-1:0];
        cand1 = sum1[PM_W] ? '1 : sum1[PM_W-1:0];
        // Ties go to the b0=0 predecessor.
        decision = (cand1 < cand0);
        pm_new   = decision ? cand1 : cand0;
    end

endmodule

// File: rtl/viterbi_bmu_acs.sv
// Branch-metric and ACS stage: runs one frame of the 4-state trellis and publishes survivors.
module viterbi_bmu_acs
    import viterbi_pkg::*;
#(
    parameter int unsigned NUM_STEPS  = 8,
    parameter int unsigned NUM_STATES = 4,
    parameter int unsigned PM_W       = 5
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic                            i_valid,
    input  logic [1:0]                      i_sym,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [NUM_STEPS*NUM_STATES-1:0] o_decisions,
    output logic [1:0]                      o_best_state,
    output logic [PM_W-1:0]                 o_best_metric
);

    localparam int unsigned CW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(NUM_STEPS - 1);

    fsm_t state_q, state_d;

    logic [CW-1:0]                   step_q;
    logic [PM_W-1:0]                 pm_q   [NUM_STATES];
    logic [PM_W-1:0]                 pm_new [NUM_STATES];
    logic [PM_W-1:0]                 pm_p0  [NUM_STATES];
    logic [PM_W-1:0]                 pm_p1  [NUM_STATES];
    logic [1:0]                      bm0    [NUM_STATES];
    logic [1:0]                      bm1    [NUM_STATES];
    logic [NUM_STATES-1:0]           dec_col;
    logic [NUM_STEPS*NUM_STATES-1:0] work_dec;
    logic [NUM_STEPS*NUM_STATES-1:0] dec_next;
    state_t                          best_s;
    logic [PM_W-1:0]                 best_m;
    logic                            step_en;
    logic                            last_step;

    function automatic logic [1:0] hamming2(input logic [1:0] x);
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    // Next state {u,b1} is reached from {b1,0} and {b1,1} with input u.
    always_comb begin
        for (int unsigned s = 0; s < NUM_STATES; s++) begin
            state_t ns;
            state_t p0;
            state_t p1;
            ns       = state_t'(s);
            p0       = {ns[0], 1'b0};
            p1       = {ns[0], 1'b1};
            pm_p0[s] = pm_q[p0];
            pm_p1[s] = pm_q[p1];
            bm0[s]   = hamming2(i_sym ^ exp_sym(p0, ns[1]));
            bm1[s]   = hamming2(i_sym ^ exp_sym(p1, ns[1]));
        end
    end

    for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
        viterbi_acs_node #(.PM_W(PM_W)) u_node (
            .pm0      (pm_p0[g]),
            .pm1      (pm_p1[g]),
            .bm0      (bm0[g]),
            .bm1      (bm1[g]),
            .pm_new   (pm_new[g]),
            .decision (dec_col[g])
        );
    end

    always_comb begin
        best_s = '0;
        best_m = pm_new[0];
        for (int unsigned s = 1; s < NUM_STATES; s++) begin
            if (pm_new[s] < best_m) begin
                best_s = state_t'(s);
                best_m = pm_new[s];
            end
        end
    end

    always_comb begin
        dec_next = work_dec;
        dec_next[int'(step_q)*NUM_STATES +: NUM_STATES] = dec_col;
    end

    assign step_en   = (state_q == RUN) && i_valid && !i_start;
    assign last_step = (step_q == LAST_STEP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            IDLE: ;
            RUN: begin
                o_busy = 1'b1;
                if (i_valid && last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_start) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            step_q        <= '0;
            work_dec      <= '0;
            o_decisions   <= '0;
            o_best_state  <= '0;
            o_best_metric <= '0;
            for (int unsigned s = 0; s < NUM_STATES; s++) begin
                pm_q[s] <= (s == 0) ? '0 : '1;
            end
        end else if (i_start) begin
            step_q   <= '0;
            work_dec <= '0;
            for (int unsigned s = 0; s < NUM_STATES; s++) begin
                pm_q[s] <= (s == 0) ? '0 : '1;
            end
        end else if (step_en) begin
            step_q   <= step_q + 1'b1;
            work_dec <= dec_next;
            for (int unsigned s = 0; s < NUM_STATES; s++) begin
                pm_q[s] <= pm_new[s];
            end
            if (last_step) begin
                o_decisions   <= dec_next;
                o_best_state  <= best_s;
                o_best_metric <= best_m;
            end
        end
    end

endmodule
